// File: rtl/envelope_sample_formatter.sv
// ADSR envelope applied to a 1-bit square wave, emitted as signed 24-bit samples
// at a fixed tick rate over a valid/ready handshake with overrun reporting.
module envelope_sample_formatter #(
   parameter int unsigned SAMPLE_DIV    = 1042,
   parameter int unsigned ATTACK_STEP   = 4,
   parameter int unsigned DECAY_STEP    = 1,
   parameter int unsigned SUSTAIN_LEVEL = 128,
   parameter int unsigned RELEASE_STEP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wave_in,
   input  logic        gate,
   input  logic        sample_ready,
   output logic [23:0] sample_out,
   output logic        sample_valid,
   output logic [2:0]  env_state,
   output logic        overrun
);

   localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_t;

   env_t          state;
   logic [7:0]    level;
   logic [CW-1:0] count;
   logic          tick;

   logic [8:0]    attack_sum;
   logic [8:0]    decay_diff;
   logic [8:0]    release_diff;
   logic [7:0]    attack_level;
   logic [7:0]    decay_level;
   logic [7:0]    release_level;
   logic [23:0]   mag;
   logic [23:0]   new_sample;

   assign tick      = (count == CW'(SAMPLE_DIV - 1));
   assign env_state = state;

   // Saturating 9-bit arithmetic; bit 8 flags carry (add) or borrow (subtract).
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      attack_sum    = {1'b0, level} + 9'(ATTACK_STEP);
      decay_diff    = {1'b0, level} - 9'(DECAY_STEP);
      release_diff  = {1'b0, level} - 9'(RELEASE_STEP);

      attack_level  = attack_sum[8] ? 8'd255 : attack_sum[7:0];
      decay_level   = (decay_diff[8] || (decay_diff[7:0] < 8'(SUSTAIN_LEVEL)))
                      ? 8'(SUSTAIN_LEVEL) : decay_diff[7:0];
      release_level = release_diff[8] ? 8'd0 : release_diff[7:0];

      mag           = {1'b0, level, 15'b0};
      new_sample    = wave_in ? mag : (~mag + 24'd1);
   end

   // NOTE: registered state uses non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         level        <= 8'd0;
         count        <= '0;
         sample_out   <= 24'd0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         count   <= tick ? '0 : count + CW'(1);
         overrun <= tick && sample_valid && !sample_ready;

         if (tick) begin
            sample_out   <= new_sample;
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end

         if (tick) begin
            unique case (state)
               IDLE: begin
                  level <= 8'd0;
                  if (gate) state <= ATTACK;
               end
               ATTACK: begin
                  if (!gate) begin
                     state <= RELEASE;
                  end else begin
                     level <= attack_level;
                     if (attack_level == 8'd255) state <= DECAY;
                  end
               end
               DECAY: begin
                  if (!gate) begin
                     state <= RELEASE;
                  end else begin
                     level <= decay_level;
                     if (decay_level == 8'(SUSTAIN_LEVEL)) state <= SUSTAIN;
                  end
               end
               SUSTAIN: begin
                  if (!gate) state <= RELEASE;
               end
               RELEASE: begin
                  // Retrigger resumes the attack from wherever the release got to.
                  if (gate) begin
                     state <= ATTACK;
                  end else begin
                     level <= release_level;
                     if (release_level == 8'd0) state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
                  level <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/envelope_sample_formatter.md
Name: envelope_sample_formatter

Overview:
- Downstream of the note-playing controller: consumes its 1-bit square wave (wave_out) and a key-held gate.
- Applies an ADSR amplitude envelope and produces signed 24-bit audio samples at a fixed sample rate.
- Delivers samples to the audio codec write interface with a valid/ready handshake.

Parameters:
- SAMPLE_DIV, 1042, clock cycles per sample tick (50 MHz to about 48 kHz); legal range 2 or more.
- ATTACK_STEP, 4, level increment per tick in ATTACK (1..255).
- DECAY_STEP, 1, level decrement per tick in DECAY (1..255).
- SUSTAIN_LEVEL, 128, level held in SUSTAIN (0..255).
- RELEASE_STEP, 2, level decrement per tick in RELEASE (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- wave_in  in  1  square-wave value from the note controller (1 = high half-cycle).
- gate  in  1  1 while a note is held.
- sample_ready  in  1  codec accepts sample this cycle.
- sample_out  out  24  signed two's-complement sample.
- sample_valid  out  1  sample_out holds an unconsumed sample.
- env_state  out  3  current envelope state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- overrun  out  1  one-cycle pulse when an unconsumed sample is overwritten.

Behaviour:
- Reset (synchronous, active-high, checked at the clk edge):
  - Tick counter, level, sample_out, sample_valid and overrun all clear to 0.
  - env_state returns to IDLE.
  - Reset mid-note or mid-handshake discards the pending sample. No transfer occurs in the reset cycle.
- Tick generation:
  - The counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is internal and high in the cycle where counter == SAMPLE_DIV-1.
  - The first tick falls in cycle SAMPLE_DIV-1 after reset deassertion; after that, one tick every SAMPLE_DIV cycles.
- Envelope: 8-bit unsigned level. gate is sampled, and level and state update, only on tick edges. Transitions on a tick:
  - IDLE: level = 0. If gate=1, go to ATTACK.
  - ATTACK:
    - If gate=0, go to RELEASE with level unchanged.
    - Otherwise level = min(level+ATTACK_STEP, 255). When the result is 255, go to DECAY.
  - DECAY:
    - If gate=0, go to RELEASE.
    - Otherwise level = max(level-DECAY_STEP, SUSTAIN_LEVEL). When the result equals SUSTAIN_LEVEL, go to SUSTAIN.
  - SUSTAIN: level is held. If gate=0, go to RELEASE.
  - RELEASE:
    - If gate=1, go to ATTACK from the current level (retrigger with no reset to 0).
    - Otherwise level = max(level-RELEASE_STEP, 0). When the result is 0, go to IDLE.
  - All add/subtract is done at 9 bits and then saturated. Wrap-around is never permitted.
- Sample formation, on the tick edge:
  - Uses the pre-update level and the wave_in value present in the tick cycle.
  - mag = {1'b0, level, 15'b0}.
  - sample_out = wave_in ? mag : -mag (24-bit two's complement).
  - level 0 yields 0 for either wave_in value.
- Handshake:
  - sample_valid rises on the tick edge, so latency is 1 clk from tick.
  - A transfer occurs in any cycle with sample_valid=1 and sample_ready=1. sample_valid falls on the next edge unless a tick coincides.
  - Tick and transfer in the same cycle: the new sample loads, sample_valid stays 1, overrun stays 0.
  - Tick while sample_valid=1 and sample_ready=0: sample_out is overwritten with the new sample, sample_valid stays 1, and overrun is 1 for exactly the following cycle.
  - sample_out is stable while sample_valid=1 and no tick occurs.
  - sample_ready is ignored when sample_valid=0.

Test Plan:
- Reset and tick cadence (SAMPLE_DIV=4):
  - Stimulus: hold reset 2 cycles, then release with gate=0 and sample_ready=1.
  - Required: all outputs 0 during reset; sample_valid pulses 1 cycle every 4 cycles; sample_out=0; env_state=0.
- Attack ramp (ATTACK_STEP=64, wave_in=1, gate=1):
  - Levels go 0, 64, 128, 192, 255, then env_state=2.
  - sample_out sequence: 0x000000, 0x200000, 0x400000, 0x600000, 0x7F8000.
  - With wave_in=0 at level 64: 0xE00000.
- Decay, sustain and release (DECAY_STEP=64, SUSTAIN_LEVEL=128, RELEASE_STEP=100):
  - From 255: decay gives 191, then 128 with SUSTAIN entered.
  - Drop gate: release gives 28, then 0, then IDLE.
  - Raise gate at level 28 instead: ATTACK resumes with 92.
- Backpressure:
  - Stimulus: hold sample_ready=0 across 2 ticks.
  - Required: overrun pulses once per overwriting tick; sample_out shows the latest sample; raising sample_ready for 1 cycle clears sample_valid the next cycle.
- Coincident tick and transfer:
  - Stimulus: sample_ready=1 in the tick cycle with sample_valid=1.
  - Required: sample_valid remains 1, the new value loads, overrun=0.
- Reset mid-SUSTAIN with sample_valid=1:
  - Required: next cycle sample_valid=0, env_state=0, level=0; the tick counter restarts from 0.
